dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller between the CPU load/store port and main memory. It serves read hits in zero wait cycles and stalls the CPU on read misses and all writes. On a read miss it refills a 4-word line from main memory; each write goes to main memory as a held single-word request. It is the initiator side of the main memory request/`done` handshake.

## Interface
- `INDEX_W`, 3: line index width; the cache holds 2^INDEX_W lines of 4 × 32-bit words.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_read`  in  1  load request; held by the CPU while `cpu_stall`=1.
- `cpu_write`  in  1  store request; held while `cpu_stall`=1.
- `cpu_addr`  in  10  word address: [1:0] offset, [INDEX_W+1:2] index, [9:INDEX_W+2] tag.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid in any cycle with `cpu_read`=1 and `cpu_stall`=0.
- `cpu_stall`  out  1  combinational; the CPU holds its request while it is 1.
- `mem_address`  out  10  word address to memory; registered.
- `mem_wdata`  out  32  write data to memory; registered.
- `mem_write`  out  1  write request; held until `mem_done`.
- `mem_read_req`  out  1  line-read request; held until `mem_done`.
- `mem_rdata`  in  128  line at `{mem_address[9:2],2'b00}`, word 0 in [31:0]; combinational from memory.
- `mem_done`  in  1  registered one-cycle completion pulse from memory.

## Operation
- Storage: per line, `valid`, `tag`, and 128-bit `data`. Hit = `valid[index]` && `tag[index]`==`cpu_addr` tag field.
- FSM states: IDLE, REFILL, WRITE_MEM.
- IDLE:
  - Read hit: `cpu_rdata` = `data[index]` word `cpu_addr[1:0]`; `cpu_stall`=0; stay in IDLE.
  - Read miss: `cpu_stall`=1. Register `mem_address`={`cpu_addr[9:2]`,2'b00} and `mem_read_req`=1. Go to REFILL.
  - Write:
    - `cpu_stall`=1.
    - On a hit, update that word in `data[index]` at this edge. On a miss, leave the cache untouched (no allocate).
    - Register `mem_address`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `mem_write`=1. Go to WRITE_MEM.
  - `cpu_read` and `cpu_write` both 1: treated as a write.
  - No request: `cpu_stall`=0; `mem_done` is ignored.
- REFILL: `cpu_stall`=1. On `mem_done`=1:
  - Write `mem_rdata` into `data[index]`, set `tag` and `valid`.
  - Clear `mem_read_req` and go to IDLE.
  - The following IDLE cycle hits and returns the word.
- WRITE_MEM: `cpu_stall`=1. On `mem_done`=1, clear `mem_write` and go to IDLE. Memory rewrites the same word on every held cycle, which is harmless.
- Index, tag, and offset used in REFILL/WRITE_MEM come from the latched `mem_address`, not `cpu_addr`.
- `mem_write` and `mem_read_req` are never both 1.

## Timing
- Reset values: state IDLE, all `valid`=0, `mem_write`=0, `mem_read_req`=0, `mem_address`=0, `mem_wdata`=0. `cpu_stall`=0 unless a request is present. `tag`/`data` are not reset.
- Read hit latency: 0 cycles, combinational `cpu_rdata`.
- Memory completes after 4 held request cycles and pulses `mem_done` in the 5th.
- Miss or write issued in cycle 0 (IDLE):
  - Request is high cycles 1–5.
  - `mem_done` arrives in cycle 5.
  - FSM returns to IDLE at cycle 6.
  - `cpu_stall` is high cycles 0–5 (6 cycles).
- Request remains high in the `mem_done` cycle and drops the next cycle. Memory tolerates this overlap because its count is held at 0.
- `rst` asserted mid-REFILL/WRITE_MEM:
  - Requests drop immediately (asynchronous reset) and state goes to IDLE.
  - A partial refill leaves the line invalid.
  - A stray `mem_done` after reset is ignored in IDLE.

## Test plan
- Reset, then read addr 0x004 with memory line 0x004–0x007 = {0xD,0xC,0xB,0xA} → `mem_read_req` cycles 1–5, stall 6 cycles; cycle 6 `cpu_rdata`=0xA, stall 0.
- Read 0x006 immediately after the refill above → hit, stall 0 same cycle, `cpu_rdata`=0xC, no memory request.
- Write 0x005=0x1234 (hit line) → `mem_write`=1 with `mem_address`=0x005, `mem_wdata`=0x1234 for 5 cycles, stall 6 cycles; a following read of 0x005 hits and returns 0x1234.
- Write 0x3E0=0x55 on an invalid line → memory word written, line stays invalid; a following read of 0x3E0 misses and refills, returning 0x55.
- Conflict: read 0x004, then 0x024 (same index 1, different tag) → second read misses and refills; re-reading 0x004 misses again.
- Assert `rst` in cycle 3 of a REFILL → `mem_read_req`=0 immediately, stall 0; re-reading the same address misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits return in zero wait cycles; misses refill a 4-word line.
module dcache_ctrl #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [9:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_stall,
    output logic [9:0]   mem_address,
    output logic [31:0]  mem_wdata,
    output logic         mem_write,
    output logic         mem_read_req,
    input  logic [127:0] mem_rdata,
    input  logic         mem_done
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 8 - INDEX_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM} state_t;

    state_t state, state_nx;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [127:0]     data [LINES];

    logic [INDEX_W-1:0] cpu_idx, mem_idx;
    logic [TAG_W-1:0]   cpu_tag, mem_tag;
    logic [127:0]       cpu_line;
    logic               hit;
    logic               issue_rd, issue_wr, refill_done;

    assign cpu_idx  = cpu_addr[INDEX_W+1:2];
    assign cpu_tag  = cpu_addr[9:INDEX_W+2];
    assign mem_idx  = mem_address[INDEX_W+1:2];
    assign mem_tag  = mem_address[9:INDEX_W+2];
    assign cpu_line = data[cpu_idx];
    assign hit      = valid[cpu_idx] && (tags[cpu_idx] == cpu_tag);
    assign cpu_rdata = cpu_line[{cpu_addr[1:0], 5'b0} +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A simultaneous read and write is handled as a write.
    always_comb begin
        state_nx    = state;
        cpu_stall   = 1'b0;
        issue_rd    = 1'b0;
        issue_wr    = 1'b0;
        refill_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_write) begin
                    cpu_stall = 1'b1;
                    issue_wr  = 1'b1;
                    state_nx  = WRITE_MEM;
                end else if (cpu_read && !hit) begin
                    cpu_stall = 1'b1;
                    issue_rd  = 1'b1;
                    state_nx  = REFILL;
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                if (mem_done) begin
                    refill_done = 1'b1;
                    state_nx    = IDLE;
                end
            end
            WRITE_MEM: begin
                cpu_stall = 1'b1;
                if (mem_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address  <= '0;
            mem_wdata    <= '0;
            mem_write    <= 1'b0;
            mem_read_req <= 1'b0;
            valid        <= '0;
        end else begin
            if (issue_wr) begin
                mem_address <= cpu_addr;
                mem_wdata   <= cpu_wdata;
                mem_write   <= 1'b1;
            end else if (issue_rd) begin
                mem_address  <= {cpu_addr[9:2], 2'b00};
                mem_read_req <= 1'b1;
            end
            if (state != IDLE && mem_done) begin
                mem_write    <= 1'b0;
                mem_read_req <= 1'b0;
            end
            if (refill_done) valid[mem_idx] <= 1'b1;
        end
    end

    // Line storage is not reset; valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            data[mem_idx] <= mem_rdata;
            tags[mem_idx] <= mem_tag;
        end else if (issue_wr && hit) begin
            data[cpu_idx][{cpu_addr[1:0], 5'b0} +: 32] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: memory responder, reference
// model of cache residency and memory contents, per-cycle comparator.
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_read, cpu_write;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic [9:0]   mem_address;
    logic [31:0]  mem_wdata;
    logic         mem_write, mem_read_req;
    logic [127:0] mem_rdata;
    logic         mem_done;

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_W(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read_req(mem_read_req),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] v;
        v = 32'hA000_0000 + i;
        case (i)
            4:  v = 32'hA;
            5:  v = 32'hB;
            6:  v = 32'hC;
            7:  v = 32'hD;
            36: v = 32'h2424;
            default: ;
        endcase
        return v;
    endfunction

    // Main memory: 4 held request cycles, done pulse in the 5th.
    logic [31:0] mem [1024];
    bit          minit = 1'b0;
    logic [1:0]  mcnt = 2'd0;
    logic        done_q = 1'b0;
    logic        inject = 1'b0;

    assign mem_done  = done_q | inject;
    assign mem_rdata = {mem[{mem_address[9:2], 2'd3}],
                        mem[{mem_address[9:2], 2'd2}],
                        mem[{mem_address[9:2], 2'd1}],
                        mem[{mem_address[9:2], 2'd0}]};

    always @(posedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
            minit <= 1'b1;
        end
        if (mem_write) mem[mem_address] <= mem_wdata;
        if ((mem_read_req || mem_write) && !done_q) begin
            if (mcnt == 2'd3) begin
                done_q <= 1'b1;
                mcnt   <= 2'd0;
            end else begin
                mcnt <= mcnt + 2'd1;
            end
        end else begin
            done_q <= 1'b0;
            if (!(mem_read_req || mem_write)) mcnt <= 2'd0;
        end
    end

    // Reference model: memory is the truth (write-through), cache
    // residency tracked as the resident line number per index.
    logic [31:0] ref_mem [1024];
    int          cached [8];

    int nerr = 0;
    int nchk = 0;

    logic        ck_en = 1'b0;
    logic        exp_stall, exp_rreq, exp_wr, exp_rden;
    logic [9:0]  exp_addr;
    logic [31:0] exp_wdata, exp_rdata;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ck_en) begin
            check("stall", {31'b0, cpu_stall}, {31'b0, exp_stall});
            check("mem_read_req", {31'b0, mem_read_req}, {31'b0, exp_rreq});
            check("mem_write", {31'b0, mem_write}, {31'b0, exp_wr});
            if (exp_rreq || exp_wr)
                check("mem_address", {22'b0, mem_address}, {22'b0, exp_addr});
            if (exp_wr) check("mem_wdata", mem_wdata, exp_wdata);
            if (exp_rden) check("cpu_rdata", cpu_rdata, exp_rdata);
        end
    end

    task automatic set_idle_exp();
        exp_stall = 1'b0;
        exp_rreq  = 1'b0;
        exp_wr    = 1'b0;
        exp_rden  = 1'b0;
    endtask

    task automatic idle(input int n);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        set_idle_exp();
        ck_en = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expectations for cycle c of a transaction started in cycle 0.
    task automatic set_exp(input bit wr, input bit miss, input int c,
                           input int last, input logic [9:0] a,
                           input logic [31:0] d);
        exp_stall = miss && c <= 5;
        exp_rreq  = !wr && miss && c >= 1 && c <= 5;
        exp_wr    = wr && c >= 1 && c <= 5;
        exp_addr  = wr ? a : {a[9:2], 2'b00};
        exp_wdata = d;
        exp_rden  = !wr && c == last;
        exp_rdata = ref_mem[a];
    endtask

    // kind: 0 read, 1 write, 2 read+write (acts as write)
    task automatic do_op(input int kind, input logic [9:0] a,
                         input logic [31:0] d, input logic [31:0] lit);
        bit wr;
        bit miss;
        int last;
        wr   = (kind != 0);
        miss = wr || (cached[a[4:2]] != int'(a[9:2]));
        last = wr ? 5 : (miss ? 6 : 0);
        cpu_read  = (kind != 1);
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        for (int c = 0; c <= last; c++) begin
            set_exp(wr, miss, c, last, a, d);
            ck_en = 1'b1;
            @(negedge clk);
            if (exp_rden) check("rdata_literal", cpu_rdata, lit);
            @(posedge clk);
            #1;
            if (!wr && miss && c == 5) cached[a[4:2]] = int'(a[9:2]);
        end
        if (wr) ref_mem[a] = d;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 8; i++) cached[i] = -1;
        rst = 1'b1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        set_idle_exp();
        exp_addr = '0;
        exp_wdata = '0;
        exp_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'b0, cpu_stall}, 32'd0);
        check("reset_rreq", {31'b0, mem_read_req}, 32'd0);
        check("reset_mwr", {31'b0, mem_write}, 32'd0);
        check("reset_maddr", {22'b0, mem_address}, 32'd0);
        check("reset_mwdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        do_op(0, 10'h004, 32'h0, 32'hA);
        do_op(0, 10'h006, 32'h0, 32'hC);
        idle(1);
        do_op(1, 10'h005, 32'h1234, 32'h0);
        do_op(0, 10'h005, 32'h0, 32'h1234);
        idle(1);
        do_op(1, 10'h3E0, 32'h55, 32'h0);
        idle(1);
        do_op(0, 10'h3E0, 32'h0, 32'h55);
        do_op(0, 10'h004, 32'h0, 32'hA);
        do_op(0, 10'h024, 32'h0, 32'h2424);
        do_op(0, 10'h004, 32'h0, 32'hA);
        do_op(2, 10'h006, 32'h77, 32'h0);
        do_op(0, 10'h006, 32'h0, 32'h77);
        idle(1);

        // Reset in cycle 3 of a refill of 0x104.
        cpu_read = 1'b1;
        cpu_addr = 10'h104;
        for (int c = 0; c < 3; c++) begin
            set_exp(1'b0, 1'b1, c, 6, 10'h104, 32'h0);
            ck_en = 1'b1;
            @(posedge clk);
            #1;
        end
        ck_en = 1'b0;
        rst = 1'b1;
        cpu_read = 1'b0;
        #1;
        check("rst_mid_rreq", {31'b0, mem_read_req}, 32'd0);
        check("rst_mid_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_mid_mwr", {31'b0, mem_write}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cached[i] = -1;
        inject = 1'b1;
        idle(1);
        inject = 1'b0;
        idle(2);
        do_op(0, 10'h104, 32'h0, 32'hA000_0104);
        do_op(0, 10'h006, 32'h0, 32'h77);
        idle(2);

        ck_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
